// File: rtl/gemm_step_scheduler.sv
// Step scheduler for a tau-MAC GEMM array: it fetches one operand slice per K step, issues the
// start and clear pulses, waits out each MAC step and the drain, then hands off the result.
module gemm_step_scheduler #(
  parameter int DIM          = 16,
  parameter int STEP_CYCLES  = 8,
  parameter int DRAIN_CYCLES = 2,
  parameter int K_W          = 8,
  parameter int STALL_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [K_W-1:0]     cmd_k_steps,
  output logic               op_req,
  output logic [K_W-1:0]     op_idx,
  input  logic               op_valid,
  output logic               mac_start,
  output logic               mac_clear,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam int TMR_W     = $clog2(STEP_CYCLES + 1);
  localparam int DRAIN_LEN = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES : 1;
  localparam int DRN_W     = $clog2(DRAIN_LEN + 1);

  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(STEP_CYCLES - 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_LEN - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]         r_state;
  logic [K_W-1:0]     r_step;
  logic [K_W-1:0]     r_k_total;
  logic [TMR_W-1:0]   r_timer;
  logic [DRN_W-1:0]   r_drain;
  logic [STALL_W-1:0] r_stall;

  logic w_in_idle;
  logic w_in_fetch;
  logic w_fire;
  logic w_empty_job;

  assign w_in_idle   = (r_state == S_IDLE);
  assign w_in_fetch  = (r_state == S_FETCH);
  assign w_fire      = w_in_fetch && op_valid;
  assign w_empty_job = w_in_idle && cmd_valid && (cmd_k_steps == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_step    <= '0;
      r_k_total <= '0;
      r_timer   <= '0;
      r_drain   <= '0;
      r_stall   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_k_total <= cmd_k_steps;
            r_step    <= '0;
            r_stall   <= '0;
            r_timer   <= '0;
            r_drain   <= '0;
            r_state   <= (cmd_k_steps == '0) ? S_DRAIN : S_FETCH;
          end
        end
        S_FETCH: begin
          if (op_valid) begin
            r_timer <= '0;
            r_state <= S_RUN;
          end else if (r_stall != '1) begin
            r_stall <= r_stall + 1'b1;
          end
        end
        S_RUN: begin
          if (r_timer == TMR_LAST) begin
            r_timer <= '0;
            // Only the last slice goes on to drain; every other slice refetches.
            if (r_step == r_k_total - K_W'(1)) begin
              r_drain <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_step  <= r_step + 1'b1;
              r_state <= S_FETCH;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            r_state <= S_RESULT;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pulses are masked during reset so that an aborted FETCH cannot leak a start.
  assign mac_start    = !reset && w_fire;
  assign mac_clear    = !reset && ((w_fire && (r_step == '0)) || w_empty_job);
  assign cmd_ready    = w_in_idle;
  assign busy         = !w_in_idle;
  assign op_req       = w_in_fetch;
  assign op_idx       = r_step;
  assign res_valid    = (r_state == S_RESULT);
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_gemm_step_scheduler.sv
// Bench for gemm_step_scheduler: directed and randomized jobs are checked cycle by cycle
// against an arithmetic timeline built from the per-slice stall counts.
module tb_gemm_step_scheduler;

  localparam int S  = 8;
  localparam int D  = 2;
  localparam int DL = (D > 0) ? D : 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_k_steps;
  logic        op_req;
  logic [7:0]  op_idx;
  logic        op_valid;
  logic        mac_start;
  logic        mac_clear;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic [15:0] stall_cycles;

  int n_vec = 0;
  int n_bad = 0;
  int fb[257];
  int sa[257];
  int stl[257];

  gemm_step_scheduler #(
    .DIM(16), .STEP_CYCLES(S), .DRAIN_CYCLES(D), .K_W(8), .STALL_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k_steps(cmd_k_steps),
    .op_req(op_req), .op_idx(op_idx), .op_valid(op_valid),
    .mac_start(mac_start), .mac_clear(mac_clear),
    .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Runs one job; the start of slice i lands stl[i] cycles after its fetch window opens.
  task automatic run_job(input int k, input int rdelay);
    int rv;
    int rel;
    int acc;
    int w;
    bit in_win;
    bit is_start;
    fb[0] = 1;
    for (int i = 0; i < k; i++) begin
      sa[i]     = fb[i] + stl[i];
      fb[i + 1] = sa[i] + S + 1;
    end
    rv  = (k > 0) ? sa[k - 1] + S + 1 + DL : 1 + DL;
    rel = rv + rdelay;

    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_k_steps = 8'(k);
    op_valid    = 1'($urandom);
    res_ready   = 1'($urandom);
    #1;
    chk("accept_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("accept_busy", 32'(busy), 32'd0);
    chk("accept_mac_start", 32'(mac_start), 32'd0);
    chk("accept_mac_clear", 32'(mac_clear), 32'(k == 0));
    chk("accept_res_valid", 32'(res_valid), 32'd0);

    acc = 0;
    w   = 0;
    for (int c = 1; c <= rel + 1; c++) begin
      @(negedge clk);
      in_win      = (w < k) && (c >= fb[w]) && (c <= sa[w]);
      is_start    = in_win && (c == sa[w]);
      cmd_valid   = (c <= rel) ? 1'($urandom) : 1'b0;
      cmd_k_steps = 8'($urandom);
      op_valid    = in_win ? is_start : 1'($urandom);
      res_ready   = (c >= rv) ? (c == rel) : 1'($urandom);
      #1;
      chk("busy", 32'(busy), 32'(c <= rel));
      chk("cmd_ready", 32'(cmd_ready), 32'(c > rel));
      chk("op_req", 32'(op_req), 32'(in_win));
      if (in_win) chk("op_idx", 32'(op_idx), 32'(w));
      chk("mac_start", 32'(mac_start), 32'(is_start));
      chk("mac_clear", 32'(mac_clear), 32'(is_start && (w == 0)));
      chk("res_valid", 32'(res_valid), 32'((c >= rv) && (c <= rel)));
      chk("stall_cycles", 32'(stall_cycles), 32'((acc > 65535) ? 65535 : acc));
      if (in_win && !is_start) acc++;
      if (is_start) w++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_k_steps = '0;
    op_valid    = 1'b0;
    res_ready   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, with op_valid high to show it has no effect in IDLE.
    reset    = 1'b0;
    op_valid = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_req", 32'(op_req), 32'd0);
    chk("rst_op_idx", 32'(op_idx), 32'd0);
    chk("rst_mac_start", 32'(mac_start), 32'd0);
    chk("rst_mac_clear", 32'(mac_clear), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);

    // Single slice: start+clear at 1, result at 12.
    stl[0] = 0;
    run_job(1, 0);
    // Three slices: starts at 1, 10, 19, result at 30.
    for (int i = 0; i < 3; i++) stl[i] = 0;
    run_job(3, 0);
    // Second fetch stalls five cycles: result at 26.
    stl[0] = 0; stl[1] = 5;
    run_job(2, 0);
    // Empty job: clear on accept, result at 3, held while res_ready is low.
    run_job(0, 4);

    // Reset in the RUN phase of a four-slice job.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_k_steps = 8'd4; op_valid = 1'b1; res_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      reset     = (c == 5);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_op_req", 32'(op_req), 32'd0);
    chk("midrst_op_idx", 32'(op_idx), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_stall", 32'(stall_cycles), 32'd0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      op_valid = 1'($urandom);
      #1;
      chk("midrst_no_start", 32'(mac_start), 32'd0);
      chk("midrst_idle", 32'(busy), 32'd0);
    end
    stl[0] = 0;
    run_job(1, 0);

    // Long stall saturates the counter; the next job clears it.
    stl[0] = 70000;
    run_job(1, 0);
    stl[0] = 1; stl[1] = 0;
    run_job(2, 1);

    // Deepest job: no wrap of the step index.
    for (int i = 0; i < 255; i++) stl[i] = (i % 50 == 7) ? 2 : 0;
    run_job(255, 0);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      int k;
      k = $urandom_range(0, 6);
      for (int i = 0; i < k; i++) stl[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      run_job(k, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
